// File: rtl/imem_responder_pkg.sv
`default_nettype none
// =============================================================================
// imem_responder_pkg : shared fetch-bus types, FSM state encoding, reset PC
// Revision: 1.0
// =============================================================================
package imem_responder_pkg;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

endpackage : imem_responder_pkg
`default_nettype wire

// File: rtl/imem_lasthit_buf.sv
`default_nettype none
// =============================================================================
// imem_lasthit_buf : one-entry (addr, data, valid) buffer of the last response;
// exists only when IMEM_LASTHIT_EN is defined.  Revision: 1.0
// =============================================================================
`ifdef IMEM_LASTHIT_EN
module imem_lasthit_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        wr_en_i,
    input  logic [63:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [63:0] rd_addr_i,
    output logic        hit_o,
    output logic [31:0] rd_data_o
);
    logic        valid_q;
    logic [61:0] tag_q;
    logic [31:0] data_q;
    logic        w_unused_lsbs;

    // Flush beats a same-cycle write so a fence.i can never be lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (wr_en_i) begin
                valid_q <= 1'b1;
            end
            if (wr_en_i) begin
                tag_q  <= wr_addr_i[63:2];
                data_q <= wr_data_i;
            end
        end
    end

    assign hit_o         = valid_q && (tag_q == rd_addr_i[63:2]);
    assign rd_data_o     = data_q;
    assign w_unused_lsbs = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

endmodule : imem_lasthit_buf
`endif
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// =============================================================================
// imem_responder : instruction fetch responder in front of a 1-cycle SRAM with
// WAIT_CYCLES extra wait states. Define IMEM_LASTHIT_EN for a last-hit buffer.
// Revision: 1.0
// =============================================================================
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_WORDS   = 65536,
    parameter logic [63:0] BASE        = RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  ibus_req_t                    ireq,
    output ibus_resp_t                   iresp,
    input  logic                         flush,
    output logic                         mem_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_idx,
    input  logic [31:0]                  mem_rdata
);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] WIN_BYTES = 64'(MEM_WORDS) << 2;

    imem_state_e state_q;
    logic [3:0]  cnt_q;
    logic [63:0] addr_q;
    logic        oob_q;
    logic        cap_q;
    logic [31:0] rdata_q;
    logic [31:0] dout_q;

    logic [63:0] w_off;
    logic        w_in_range;
    logic        w_accept;
    logic        w_redirect;
    logic        w_hit;
    logic [31:0] w_buf_data;
    logic [31:0] w_fresh;
    logic [31:0] w_resp_data;
    logic        w_resp;

    assign w_off      = ireq.addr - BASE;
    assign w_in_range = (ireq.addr >= BASE) && (w_off < WIN_BYTES);
    // Gating with reset keeps every output low while reset is held.
    assign w_accept   = reset && (state_q == ST_IDLE) && ireq.valid;
    assign w_redirect = !ireq.valid || (ireq.addr != addr_q);
    assign mem_en     = w_accept && w_in_range && !w_hit;
    assign mem_idx    = mem_en ? w_off[IDX_W+1:2] : '0;

    // cap_q marks the one cycle in which the SRAM word for the access is live.
    assign w_fresh     = oob_q ? 32'h0000_0000 : mem_rdata;
    assign w_resp_data = cap_q ? w_fresh : rdata_q;
    assign w_resp      = (state_q == ST_RESP);

    always_comb begin
        iresp         = '0;
        iresp.addr_ok = w_accept;
        iresp.data_ok = w_resp;
        iresp.data    = w_resp ? w_resp_data : dout_q;
    end

`ifdef IMEM_LASTHIT_EN
    imem_lasthit_buf u_lasthit (
        .clk_i     (clk),
        .rst_ni    (reset),
        .flush_i   (flush),
        .wr_en_i   (w_resp),
        .wr_addr_i (addr_q),
        .wr_data_i (w_resp_data),
        .rd_addr_i (ireq.addr),
        .hit_o     (w_hit),
        .rd_data_o (w_buf_data)
    );
`else
    logic w_unused_flush;
    assign w_hit          = 1'b0;
    assign w_buf_data     = 32'h0000_0000;
    assign w_unused_flush = flush;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            oob_q   <= 1'b0;
            cap_q   <= 1'b0;
            rdata_q <= '0;
            dout_q  <= '0;
        end else begin
            cap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ireq.valid) begin
                        addr_q <= ireq.addr;
                        oob_q  <= !w_in_range;
                        cnt_q  <= 4'(WAIT_CYCLES);
                        if (w_hit) begin
                            rdata_q <= w_buf_data;
                            state_q <= ST_RESP;
                        end else begin
                            cap_q   <= 1'b1;
                            state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cap_q) begin
                        rdata_q <= w_fresh;
                    end
                    if (w_redirect) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    rdata_q <= w_resp_data;
                    dout_q  <= w_resp_data;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : imem_responder
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// =============================================================================
// tb_imem_responder : scoreboard bench, one DUT with WAIT_CYCLES=2 and one with 0
// Revision: 1.0
// =============================================================================
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam logic [63:0] C_BASE  = 64'h0000_0000_8000_0000;
    localparam int unsigned C_WORDS = 65536;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    ibus_req_t   ireq, ireq0;
    ibus_resp_t  iresp, iresp0;
    logic        flush, flush0;
    logic        mem_en, mem_en0;
    logic [15:0] mem_idx, mem_idx0;
    logic [31:0] mem_rdata, mem_rdata0;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q2[$];
    exp_t        q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [15:0] idx);
        return 32'h0010_0093 ^ ((32'(idx) ^ 32'd4) * 32'h9E37_79B9);
    endfunction

    always @(posedge clk) if (mem_en)  mem_rdata  <= mem_word(mem_idx);
    always @(posedge clk) if (mem_en0) mem_rdata0 <= mem_word(mem_idx0);

    imem_responder #(.WAIT_CYCLES(2), .MEM_WORDS(C_WORDS), .BASE(C_BASE)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .flush(flush),
        .mem_en(mem_en), .mem_idx(mem_idx), .mem_rdata(mem_rdata)
    );

    imem_responder #(.WAIT_CYCLES(0), .MEM_WORDS(C_WORDS), .BASE(C_BASE)) dut0 (
        .clk(clk), .reset(reset), .ireq(ireq0), .iresp(iresp0), .flush(flush0),
        .mem_en(mem_en0), .mem_idx(mem_idx0), .mem_rdata(mem_rdata0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_buf();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (iresp.data_ok !== 1'b0) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL resp_w2: unexpected data_ok at cycle %0d data %h, required none", cyc, iresp.data);
                end else begin
                    e = q2.pop_front();
                    if (cyc !== e.cyc || iresp.data !== e.data) begin
                        errors++;
                        $display("FAIL resp_w2: got cycle %0d data %h, required cycle %0d data %h", cyc, iresp.data, e.cyc, e.data);
                    end
                end
            end
            if (iresp0.data_ok !== 1'b0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL resp_w0: unexpected data_ok at cycle %0d data %h, required none", cyc, iresp0.data);
                end else begin
                    e = q0.pop_front();
                    if (cyc !== e.cyc || iresp0.data !== e.data) begin
                        errors++;
                        $display("FAIL resp_w0: got cycle %0d data %h, required cycle %0d data %h", cyc, iresp0.data, e.cyc, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        ireq.valid = 1'b1; ireq.addr = C_BASE + 64'h10;
        repeat (2) step();
        checks++; if (iresp.addr_ok !== 1'b0) begin errors++; $display("FAIL rst_addr_ok: got %b required 0", iresp.addr_ok); end
        checks++; if (iresp.data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok: got %b required 0", iresp.data_ok); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
        checks++; if (mem_idx !== 16'h0) begin errors++; $display("FAIL rst_mem_idx: got %h required 0", mem_idx); end
        checks++; if (iresp.data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h required 0", iresp.data); end
        ireq.valid = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int unsigned t;
        step();
        ireq.valid = 1'b1; ireq.addr = C_BASE + 64'h10;
        #1;
        t = cyc;
        checks++; if (iresp.addr_ok !== 1'b1) begin errors++; $display("FAIL basic_addr_ok: got %b required 1", iresp.addr_ok); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL basic_mem_en: got %b required 1", mem_en); end
        checks++; if (mem_idx !== 16'd4) begin errors++; $display("FAIL basic_mem_idx: got %0d required 4", mem_idx); end
        q2.push_back('{t + 3, 32'h0010_0093});
        step(); #1;
        checks++; if (iresp.addr_ok !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL basic_wait_quiet: got addr_ok %b mem_en %b required 0 0", iresp.addr_ok, mem_en); end
        step();
        step(); #1;
        checks++; if (iresp.addr_ok !== 1'b0) begin errors++; $display("FAIL basic_bubble: got addr_ok %b required 0", iresp.addr_ok); end
        ireq.valid = 1'b0;
        step();
        checks++; if (iresp.data_ok !== 1'b0 || iresp.data !== 32'h0010_0093) begin errors++; $display("FAIL basic_hold: got data_ok %b data %h required 0 00100093", iresp.data_ok, iresp.data); end
    endtask

    task automatic test_redirect();
        flush_buf();
        step();
        ireq.valid = 1'b1; ireq.addr = C_BASE + 64'h10;
        #1;
        checks++; if (iresp.addr_ok !== 1'b1) begin errors++; $display("FAIL redir_first_accept: got %b required 1", iresp.addr_ok); end
        step();
        ireq.addr = C_BASE + 64'h40;
        #1;
        checks++; if (iresp.addr_ok !== 1'b0) begin errors++; $display("FAIL redir_no_accept_in_wait: got %b required 0", iresp.addr_ok); end
        step(); #1;
        checks++; if (iresp.addr_ok !== 1'b1 || mem_idx !== 16'd16) begin errors++; $display("FAIL redir_second_accept: got addr_ok %b idx %0d required 1 16", iresp.addr_ok, mem_idx); end
        q2.push_back('{cyc + 3, mem_word(16'd16)});
        step();
        step();
        step();
        ireq.valid = 1'b0;
        step();
    endtask

    task automatic test_out_of_range();
        int unsigned t;
        step();
        ireq.valid = 1'b1; ireq.addr = 64'h0;
        #1;
        t = cyc;
        checks++; if (iresp.addr_ok !== 1'b1) begin errors++; $display("FAIL oob_addr_ok: got %b required 1", iresp.addr_ok); end
        q2.push_back('{t + 3, 32'h0});
        for (int k = 0; k < 3; k++) begin
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL oob_mem_en: cycle T+%0d got %b required 0", k, mem_en); end
            step(); #1;
        end
        ireq.valid = 1'b0;
        step();
    endtask

    task automatic test_bounds();
        logic [63:0] a;
        logic        en;
        logic [15:0] idx;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin a = C_BASE + 64'h13;    en = 1'b1; idx = 16'd4;      end
                1:       begin a = C_BASE + 64'h3FFFC; en = 1'b1; idx = 16'hFFFF;   end
                2:       begin a = C_BASE + 64'h40000; en = 1'b0; idx = 16'h0;      end
                default: begin a = C_BASE - 64'h4;     en = 1'b0; idx = 16'h0;      end
            endcase
            d = en ? mem_word(idx) : 32'h0;
            flush_buf();
            step();
            ireq.valid = 1'b1; ireq.addr = a;
            #1;
            checks++; if (mem_en !== en || mem_idx !== idx) begin errors++; $display("FAIL bounds_%0d: got mem_en %b idx %h required %b %h", i, mem_en, mem_idx, en, idx); end
            q2.push_back('{cyc + 3, d});
            step();
            step();
            step();
            ireq.valid = 1'b0;
        end
        step();
    endtask

    task automatic test_lasthit();
        flush_buf();
        step();
        ireq.valid = 1'b1; ireq.addr = C_BASE + 64'h10;
        #1;
        q2.push_back('{cyc + 3, 32'h0010_0093});
        step();
        step();
        step();
        ireq.valid = 1'b0;
        step();
        ireq.valid = 1'b1;
`ifdef IMEM_LASTHIT_EN
        #1;
        checks++; if (iresp.addr_ok !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL lasthit_hit: got addr_ok %b mem_en %b required 1 0", iresp.addr_ok, mem_en); end
        q2.push_back('{cyc + 1, 32'h0010_0093});
        step();
        ireq.valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ireq.valid = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL lasthit_after_flush: got mem_en %b required 1", mem_en); end
        q2.push_back('{cyc + 3, 32'h0010_0093});
`else
        flush = 1'b1;
        #1;
        checks++; if (iresp.addr_ok !== 1'b1 || mem_en !== 1'b1) begin errors++; $display("FAIL rerequest_miss: got addr_ok %b mem_en %b required 1 1", iresp.addr_ok, mem_en); end
        q2.push_back('{cyc + 3, 32'h0010_0093});
        step();
        flush = 1'b0;
        step();
        step();
        ireq.valid = 1'b0;
        step();
        ireq.valid = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rerequest_after_flush: got mem_en %b required 1", mem_en); end
        q2.push_back('{cyc + 3, 32'h0010_0093});
`endif
        step();
        step();
        step();
        ireq.valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        flush_buf();
        step();
        ireq.valid = 1'b1; ireq.addr = C_BASE + 64'h20;
        step();
        #1;
        reset = 1'b0;
        #1;
        checks++; if (iresp.addr_ok !== 1'b0 || iresp.data_ok !== 1'b0) begin errors++; $display("FAIL midrst_flags: got addr_ok %b data_ok %b required 0 0", iresp.addr_ok, iresp.data_ok); end
        checks++; if (mem_en !== 1'b0 || mem_idx !== 16'h0) begin errors++; $display("FAIL midrst_mem: got mem_en %b idx %h required 0 0", mem_en, mem_idx); end
        checks++; if (iresp.data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h required 0", iresp.data); end
        ireq.valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (iresp.data_ok !== 1'b0) begin errors++; $display("FAIL midrst_no_resp: cycle %0d got data_ok %b required 0", k, iresp.data_ok); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        step();
        ireq0.valid = 1'b1; ireq0.addr = C_BASE;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (iresp0.addr_ok !== ((k % 2) == 0)) begin errors++; $display("FAIL b2b_accept_%0d: got addr_ok %b required %b", k, iresp0.addr_ok, ((k % 2) == 0)); end
            if ((k % 2) == 0) begin
                q0.push_back('{cyc + 1, mem_word(16'(n))});
                n++;
            end
            step();
            ireq0.addr = C_BASE + 64'(4 * n);
        end
        ireq0.valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        ireq  = '0;
        ireq0 = '0;
        flush  = 1'b0;
        flush0 = 1'b0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_basic();
        test_redirect();
        test_out_of_range();
        test_bounds();
        test_lasthit();
        test_reset_mid();
        test_back_to_back();
        repeat (4) step();
        checks++; if (q2.size() != 0) begin errors++; $display("FAIL pending_w2: got %0d outstanding responses required 0", q2.size()); end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL pending_w0: got %0d outstanding responses required 0", q0.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_responder
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra SRAM wait states per miss (0..15).
REQ-002 SHALL have parameter MEM_WORDS, default 65536, meaning 32-bit words in the instruction window.
REQ-003 SHALL have parameter BASE, default 64'h80000000, meaning the byte address of word 0.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ireq, input, ibus_req_t, the request from fetch (valid, 64-bit addr).
REQ-007 SHALL have port iresp, output, ibus_resp_t, the response to fetch (addr_ok, data_ok, 32-bit data).
REQ-008 SHALL have port flush, input, 1, invalidates the last-hit buffer (fence.i).
REQ-009 SHALL have port mem_en, output, 1, the SRAM read enable.
REQ-010 SHALL have port mem_idx, output, log2(MEM_WORDS), the SRAM word index.
REQ-011 SHALL have port mem_rdata, input, 32, the SRAM data, valid one cycle after mem_en.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 IDLE with ireq.valid in cycle T SHALL assert mem_en and addr_ok combinationally in T, latch addr, load counter=WAIT_CYCLES, and go to WAIT.
REQ-014 mem_idx SHALL be (addr-BASE)>>2; addr[1:0] ignored.
REQ-015 WAIT SHALL capture mem_rdata into the data register in T+1, decrement the counter each cycle, and go to RESP when the counter reaches 0.
REQ-016 RESP SHALL drive data_ok=1 for exactly one cycle (T+1+WAIT_CYCLES) with the held data, then return to IDLE; no request is accepted in RESP (one bubble).
REQ-017 In WAIT, if ireq.valid==0 or ireq.addr differs from the latched addr (branch redirect), the FSM SHALL abort to IDLE next cycle without data_ok.
REQ-018 An address outside [BASE, BASE+4*MEM_WORDS) SHALL skip SRAM access (mem_en=0) and respond with data 32'h00000000 at the same latency.
REQ-019 data_ok and addr_ok SHALL be 0 whenever not stated above; iresp.data SHALL hold its value outside RESP.

Reset
REQ-020 On reset low: state=IDLE, counter=0, data=0, latched addr=0, last-hit buffer invalid, all outputs 0, effective immediately (asynchronous); deassertion resumes at IDLE.
REQ-021 Reset mid-WAIT SHALL discard the in-flight access; no data_ok follows.

Configuration
REQ-022 With IMEM_LASTHIT_EN defined: a one-entry buffer (addr, data, valid) SHALL be written at each RESP; IDLE with valid request and buffer hit SHALL go directly to RESP (data_ok at T+1, mem_en=0) regardless of WAIT_CYCLES.
REQ-023 flush SHALL clear buffer valid in the cycle after assertion; flush in the same cycle as a RESP write clears it (flush wins).
REQ-024 Without IMEM_LASTHIT_EN: no buffer; flush is ignored; every access follows REQ-013..016.

Structure
REQ-025 ibus_req_t, ibus_resp_t and the FSM state enum SHALL live in the shared common package; BASE default uses the package reset-PC constant.
REQ-026 The last-hit buffer SHALL be a sub-module imem_lasthit_buf, instantiated only under IMEM_LASTHIT_EN.

Verification
REQ-027 Reset, WAIT_CYCLES=2, ireq {1, 0x80000010} held, mem word 4=0x00100093 -> addr_ok in T, mem_idx=4, data_ok only in T+3 with data 0x00100093.
REQ-028 Request 0x80000010, redirect to 0x80000040 at T+1 -> no data_ok for 0x10; new request accepted after return to IDLE, data_ok carries word 16.
REQ-029 Request 0x00000000 -> mem_en never asserted; data_ok at T+3 with data 0.
REQ-030 IMEM_LASTHIT_EN, re-request 0x80000010 after completion -> data_ok next cycle, mem_en=0; after flush pulse, same request -> full latency.
REQ-031 Assert reset low at T+1 of an access -> outputs 0 immediately; after release, no data_ok until a new request.
REQ-032 WAIT_CYCLES=0, continuous sequential requests -> data_ok every second cycle (RESP bubble), data in address order.
